// File: rtl/bf16_to_int20.sv
// BF16 -> signed 20-bit fixed point (2^-24 per LSB), two-stage valid/ready pipeline.
// Optional saturation counter on the sat_count port when BF16_SAT_CNT_EN is defined.
module bf16_to_int20 #(
  parameter int DATA_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_bf16,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     out_nan
`ifdef BF16_SAT_CNT_EN
  ,
  output logic [15:0]              sat_count
`endif
);

  localparam logic signed [8:0]     SH_MAX  = 9'(DATA_W - 8);
  localparam logic [DATA_W-1:0]     MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]     MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W:0]       MAG_POS = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W:0]       MAG_NEG = {2'b01, {(DATA_W-1){1'b0}}};

  // Magnitude with one guard bit; all-ones marks a shift that overflows the output range.
  function automatic logic [DATA_W:0] shift_mag(input logic [7:0] sig,
                                                input logic signed [8:0] sh);
    logic [DATA_W:0] m;
    logic [8:0]      rsh;
    m   = '0;
    rsh = -sh;
    if (sh > SH_MAX)
      m = '1;
    else if (sh >= 9'sd0)
      m = {{(DATA_W-7){1'b0}}, sig} << sh[4:0];
    else if (rsh < 9'd8)
      m = {{(DATA_W-7){1'b0}}, sig} >> rsh[2:0];
    return m;
  endfunction

  // Returns {sat, value}; -2^(DATA_W-1) is representable and is not a clamp.
  function automatic logic [DATA_W:0] sat_negate(input logic sign,
                                                 input logic [DATA_W:0] mag);
    logic [DATA_W:0] res;
    if (!sign)
      res = (mag > MAG_POS) ? {1'b1, MAX_POS} : {1'b0, mag[DATA_W-1:0]};
    else
      res = (mag > MAG_NEG) ? {1'b1, MIN_NEG} : {1'b0, -mag[DATA_W-1:0]};
    return res;
  endfunction

  logic                     r_vld_p1;
  logic                     r_sign_p1;
  logic                     r_zero_p1;
  logic                     r_nan_p1;
  logic                     r_inf_p1;
  logic signed [8:0]        r_shift_p1;
  logic [7:0]               r_sig_p1;
  logic                     r_vld_p2;
  logic signed [DATA_W-1:0] r_data_p2;
  logic                     r_sat_p2;
  logic                     r_nan_p2;

  logic                     w_acc_p0;
  logic                     w_adv_p1;
  logic signed [8:0]        w_shift_p0;
  logic [DATA_W:0]          w_res_p1;

  assign w_adv_p1   = r_vld_p1 && (!r_vld_p2 || out_ready);
  assign in_ready   = !r_vld_p1 || w_adv_p1;
  assign w_acc_p0   = in_valid && in_ready;
  assign w_shift_p0 = $signed({1'b0, in_bf16[14:7]}) - 9'sd110;

  // Stage 1 boundary: decode sign, shift, significand and class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vld_p1 <= 1'b0;
    else if (in_ready)
      r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_acc_p0) begin
      r_sign_p1  <= in_bf16[15];
      r_zero_p1  <= (in_bf16[14:7] == 8'h00);
      r_nan_p1   <= (in_bf16[14:7] == 8'hFF) && (in_bf16[6:0] != 7'h00);
      r_inf_p1   <= (in_bf16[14:7] == 8'hFF) && (in_bf16[6:0] == 7'h00);
      r_shift_p1 <= w_shift_p0;
      r_sig_p1   <= {1'b1, in_bf16[6:0]};
    end
  end

  always_comb begin
    w_res_p1 = sat_negate(r_sign_p1, r_inf_p1 ? '1 : shift_mag(r_sig_p1, r_shift_p1));
    if (r_zero_p1 || r_nan_p1)
      w_res_p1 = '0;
  end

  // Stage 2 boundary: shifted, negated and saturated result held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_sat_p2  <= 1'b0;
      r_nan_p2  <= 1'b0;
    end else if (w_adv_p1) begin
      r_vld_p2  <= 1'b1;
      r_data_p2 <= w_res_p1[DATA_W-1:0];
      r_sat_p2  <= w_res_p1[DATA_W];
      r_nan_p2  <= r_nan_p1;
    end else if (out_ready) begin
      r_vld_p2  <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_sat   = r_sat_p2;
  assign out_nan   = r_nan_p2;

`ifdef BF16_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (r_vld_p2 && out_ready && r_sat_p2 && (r_sat_cnt != 16'hFFFF))
      r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_bf16_to_int20.sv
// Scoreboard bench for bf16_to_int20: directed vectors, backpressure, random streams,
// mid-stream reset and (with BF16_SAT_CNT_EN) the saturation counter.
module tb_bf16_to_int20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bf16 = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic        out_sat;
  logic        out_nan;
`ifdef BF16_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  int          n_out = 0;
  int          sat_model = 0;
  logic [21:0] sb_q[$];

  bf16_to_int20 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bf16   (in_bf16),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_nan   (out_nan)
`ifdef BF16_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {nan, sat, data[19:0]} computed with wide integer arithmetic.
  function automatic logic [21:0] model(input logic [15:0] b);
    int     e;
    int     sh;
    longint sig;
    longint mag;
    longint v;
    logic   sat;
    e   = int'(b[14:7]);
    sig = 128 + longint'(b[6:0]);
    if (e == 0) return 22'h0;
    if (e == 255 && b[6:0] != 7'h0) return 22'h200000;
    sh = e - 110;
    if (e == 255 || sh > 40) mag = longint'(1) <<< 44;
    else if (sh >= 0)        mag = sig <<< sh;
    else if (sh <= -8)       mag = 0;
    else                     mag = sig >>> (-sh);
    v   = b[15] ? -mag : mag;
    sat = 1'b0;
    if (v > 524287) begin
      v = 524287;
      sat = 1'b1;
    end else if (v < -524288) begin
      v = -524288;
      sat = 1'b1;
    end
    return {1'b0, sat, v[19:0]};
  endfunction

  function automatic logic [15:0] rand_bf16();
    logic [15:0] b;
    b = 16'($urandom);
    case ($urandom_range(0, 3))
      1: b[14:7] = 8'($urandom_range(100, 135));
      2: b[14:7] = 8'($urandom_range(119, 124));
      3: begin
        b[14:7] = 8'hFF;
        if ($urandom_range(0, 1) == 1) b[6:0] = 7'h0;
      end
      default: ;
    endcase
    return b;
  endfunction

  // One clock: drive at the falling edge, observe 1 time unit later; handshakes land on the next rise.
  task automatic cycle(input logic v, input logic [15:0] d, input logic r);
    logic [21:0] exp_v;
    @(negedge clk);
    in_valid  = v;
    in_bf16   = d;
    out_ready = r;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0)
        chk_eq("extra_out", 32'(out_valid), 32'h0);
      else if (out_ready) begin
        exp_v = sb_q.pop_front();
        chk_eq("data", 32'({out_nan, out_sat, out_data}), 32'(exp_v));
        n_out++;
        if (exp_v[20] && sat_model < 65535) sat_model++;
      end else
        chk_eq("hold", 32'({out_nan, out_sat, out_data}), 32'(sb_q[0]));
    end
    if (in_valid && in_ready) begin
      sb_q.push_back(model(d));
      n_acc++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 200) begin
      cycle(1'b0, 16'h0, 1'b1);
      k++;
    end
    chk_eq("drain_empty", 32'(sb_q.size()), 32'h0);
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    sb_q.delete();
    sat_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("rst_out_valid", 32'(out_valid), 32'h0);
    chk_eq("rst_in_ready", 32'(in_ready), 32'h1);
    chk_eq("rst_out_data", 32'(out_data), 32'h0);
`ifdef BF16_SAT_CNT_EN
    chk_eq("rst_sat_count", 32'(sat_count), 32'h0);
`endif
  endtask

  logic [15:0] dir_in  [10] = '{16'h3380, 16'hB380, 16'h3B7F, 16'h3D00, 16'hBD00,
                                16'hFF80, 16'h3F80, 16'h7FC0, 16'h0040, 16'h3000};
  logic [21:0] dir_exp [10] = '{22'h000001, 22'h0FFFFF, 22'h00FF00, 22'h17FFFF, 22'h080000,
                                22'h180000, 22'h17FFFF, 22'h200000, 22'h000000, 22'h000000};
  logic [15:0] bp_in   [4]  = '{16'h3B7F, 16'hB380, 16'h3D00, 16'h3380};

  initial begin
    int n0;
    int o0;
    int idx;
    int cyc;
    bit did_rst;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_eq("in_reset_out_valid", 32'(out_valid), 32'h0);
    chk_eq("in_reset_out_data", 32'(out_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_eq("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk_eq("post_rst_in_ready", 32'(in_ready), 32'h1);
    chk_eq("post_rst_flags", 32'({out_nan, out_sat}), 32'h0);
`ifdef BF16_SAT_CNT_EN
    chk_eq("post_rst_sat_count", 32'(sat_count), 32'h0);
`endif

    // Directed vectors with latency check
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, dir_in[i], 1'b1);
      cycle(1'b0, 16'h0, 1'b1);
      chk_eq("lat1_out_valid", 32'(out_valid), 32'h0);
      cycle(1'b0, 16'h0, 1'b1);
      chk_eq("lat2_out_valid", 32'(out_valid), 32'h1);
      chk_eq($sformatf("dir_%h", dir_in[i]), 32'({out_nan, out_sat, out_data}), 32'(dir_exp[i]));
    end
    drain();

    // Back-to-back burst: drain and refill without bubbles
    n0 = n_acc;
    for (int i = 0; i < 8; i++) cycle(1'b1, rand_bf16(), 1'b1);
    chk_eq("burst_accepted", 32'(n_acc - n0), 32'd8);
    drain();

    // Backpressure: 6 stalled cycles offering 4 inputs
    n0  = n_acc;
    o0  = n_out;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      int a0;
      a0 = n_acc;
      cycle(1'b1, bp_in[idx], 1'b0);
      if (n_acc != a0) idx++;
    end
    chk_eq("bp_accepted", 32'(n_acc - n0), 32'd2);
    chk_eq("bp_in_ready", 32'(in_ready), 32'h0);
    cyc = 0;
    while (idx < 4 && cyc < 50) begin
      int a0;
      a0 = n_acc;
      cycle(1'b1, bp_in[idx], 1'b1);
      if (n_acc != a0) idx++;
      cyc++;
    end
    drain();
    chk_eq("bp_delivered", 32'(n_out - o0), 32'd4);

    // Random valid/ready stream with a reset mid-stream
    n0      = n_acc;
    cyc     = 0;
    did_rst = 1'b0;
    while ((n_acc - n0) < 10000 && cyc < 40000) begin
      cycle($urandom_range(0, 9) < 9, rand_bf16(), $urandom_range(0, 9) < 9);
      cyc++;
      if (!did_rst && (n_acc - n0) >= 5000) begin
        pulse_reset();
        did_rst = 1'b1;
      end
    end
    chk_eq("rand_accepted", 32'(n_acc - n0), 32'd10000);
    drain();

`ifdef BF16_SAT_CNT_EN
    chk_eq("cnt_before", 32'(sat_count), 32'(sat_model));
    cycle(1'b1, 16'h3F80, 1'b0);
    repeat (4) cycle(1'b0, 16'h0, 1'b0);
    chk_eq("cnt_stalled", 32'(sat_count), 32'(sat_model));
    drain();
    chk_eq("cnt_after_stall", 32'(sat_count), 32'(sat_model));
    n0  = n_acc;
    cyc = 0;
    while ((n_acc - n0) < 70000 && cyc < 72000) begin
      cycle(1'b1, cyc[0] ? 16'hFF80 : 16'h3F80, 1'b1);
      cyc++;
    end
    chk_eq("cnt_sat_accepted", 32'(n_acc - n0), 32'd70000);
    drain();
    chk_eq("cnt_model", 32'(sat_count), 32'(sat_model));
    chk_eq("cnt_sticky", 32'(sat_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
